// File: rtl/clps_tx_serializer.sv
// MSB-first parallel-to-serial stage feeding the CLPS transmit pad; sends an idle word when no data is offered.
// Optional PRBS7 test source is built in only when CLPS_SER_PRBS_EN is defined.
module clps_tx_serializer #(
    parameter int unsigned WORD_W       = 32,
    parameter logic [31:0] IDLE_PATTERN = 32'hF0F0_F0F0
) (
    input  logic              ClkBitRate,
    input  logic              rst_b,
    input  logic              Enable,
    input  logic [WORD_W-1:0] WordIn,
    input  logic              WordValid,
    output logic              WordReady,
    output logic              SerOut,
    output logic              TxEn,
    output logic              FrameStart,
    output logic              FrameIsData,
    output logic [15:0]       WordCnt,
    input  logic              PrbsMode
);

    // state       | meaning
    // MODE_NORMAL | words/idle loaded at each boundary and shifted out
    // MODE_PRBS   | PRBS7 bits on SerOut, handshake closed, counter keeps framing
    typedef enum logic {
        MODE_NORMAL = 1'b0,
        MODE_PRBS   = 1'b1
    } mode_t;

    localparam int unsigned       CNT_W     = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORD_W - 1);
    localparam logic [WORD_W-1:0] IDLE_WORD = WORD_W'(IDLE_PATTERN);

    mode_t             mode, mode_nxt;
    logic [WORD_W-1:0] sh, sh_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              tx_en;
    logic              frame_start, fs_nxt;
    logic              frame_is_data, fid_nxt;
    logic [15:0]       word_cnt, wc_nxt;
    logic              boundary;
    logic              prbs_entry;

`ifdef CLPS_SER_PRBS_EN
    logic [6:0] lfsr, lfsr_nxt, lfsr_cur;

    assign prbs_entry = boundary && (mode == MODE_NORMAL) && PrbsMode;
`else
    logic unused_prbs;

    assign unused_prbs = PrbsMode;
    assign prbs_entry  = 1'b0;
`endif

    assign boundary  = Enable && (cnt == CNT_LAST);
    assign WordReady = boundary && (mode == MODE_NORMAL) && !prbs_entry;

    always_comb begin
        mode_nxt = mode;
        sh_nxt   = sh;
        cnt_nxt  = cnt;
        fs_nxt   = 1'b0;
        fid_nxt  = frame_is_data;
        wc_nxt   = word_cnt;
`ifdef CLPS_SER_PRBS_EN
        lfsr_nxt = lfsr;
        // The seed is applied on the entry edge itself so the first bit out is seed[6].
        lfsr_cur = (mode == MODE_NORMAL) ? 7'h7F : lfsr;
`endif
        if (!Enable) begin
            mode_nxt = MODE_NORMAL;
            sh_nxt   = '0;
            cnt_nxt  = CNT_LAST;
            fid_nxt  = 1'b0;
        end else begin
            cnt_nxt = boundary ? '0 : cnt + CNT_W'(1);
`ifdef CLPS_SER_PRBS_EN
            if (boundary) begin
                mode_nxt = PrbsMode ? MODE_PRBS : MODE_NORMAL;
            end
            if (mode_nxt == MODE_PRBS) begin
                sh_nxt   = {lfsr_cur[6], {(WORD_W-1){1'b0}}};
                lfsr_nxt = {lfsr_cur[5:0], lfsr_cur[6] ^ lfsr_cur[5]};
                fid_nxt  = 1'b0;
            end else
`endif
            if (boundary) begin
                fs_nxt = 1'b1;
                if (WordValid && WordReady) begin
                    sh_nxt  = WordIn;
                    fid_nxt = 1'b1;
                    wc_nxt  = word_cnt + 16'd1;
                end else begin
                    sh_nxt  = IDLE_WORD;
                    fid_nxt = 1'b0;
                end
            end else begin
                sh_nxt = sh << 1;
            end
        end
    end

    always_ff @(posedge ClkBitRate) begin
        if (!rst_b) begin
            mode          <= MODE_NORMAL;
            sh            <= '0;
            cnt           <= CNT_LAST;
            tx_en         <= 1'b0;
            frame_start   <= 1'b0;
            frame_is_data <= 1'b0;
            word_cnt      <= '0;
`ifdef CLPS_SER_PRBS_EN
            lfsr          <= '0;
`endif
        end else begin
            mode          <= mode_nxt;
            sh            <= sh_nxt;
            cnt           <= cnt_nxt;
            tx_en         <= Enable;
            frame_start   <= fs_nxt;
            frame_is_data <= fid_nxt;
            word_cnt      <= wc_nxt;
`ifdef CLPS_SER_PRBS_EN
            lfsr          <= lfsr_nxt;
`endif
        end
    end

    assign SerOut      = sh[WORD_W-1];
    assign TxEn        = tx_en;
    assign FrameStart  = frame_start;
    assign FrameIsData = frame_is_data;
    assign WordCnt     = word_cnt;

endmodule

// File: tb/tb_clps_tx_serializer.sv
// Directed bench for clps_tx_serializer (default build, 32-bit words, idle F0F0_F0F0).
module tb_clps_tx_serializer;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        prbs_mode = 1'b0;
    logic        word_ready;
    logic        ser_out;
    logic        tx_en;
    logic        frame_start;
    logic        frame_is_data;
    logic [15:0] word_cnt;

    int n_vec = 0;
    int n_err = 0;

    clps_tx_serializer #(
        .WORD_W      (32),
        .IDLE_PATTERN(32'hF0F0_F0F0)
    ) dut (
        .ClkBitRate (clk),
        .rst_b      (rst_b),
        .Enable     (enable),
        .WordIn     (word_in),
        .WordValid  (word_valid),
        .WordReady  (word_ready),
        .SerOut     (ser_out),
        .TxEn       (tx_en),
        .FrameStart (frame_start),
        .FrameIsData(frame_is_data),
        .WordCnt    (word_cnt),
        .PrbsMode   (prbs_mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        val;
        logic [31:0] word;
        logic        rdy;
        logic        ser;
        logic        txen;
        logic        fs;
        logic        fid;
        logic [15:0] wc;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b      = 1'b0;
        enable     = 1'b0;
        word_valid = 1'b0;
        step();
        rst_b = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_w;
        logic [31:0] words [3];

        // idle stream, enable gap, then one data word
        tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[11] = '{1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1};
        tbl[12] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};

        // reset dominates an active Enable and a valid word
        rst_b      = 1'b0;
        enable     = 1'b1;
        word_valid = 1'b1;
        word_in    = 32'h1234_5678;
        step();
        step();
        chk("rst_ser",  {31'd0, ser_out},       32'd0);
        chk("rst_txen", {31'd0, tx_en},         32'd0);
        chk("rst_fs",   {31'd0, frame_start},   32'd0);
        chk("rst_fid",  {31'd0, frame_is_data}, 32'd0);
        chk("rst_wc",   {16'd0, word_cnt},      32'd0);
        rst_b = 1'b1;

        for (int i = 0; i < 13; i++) begin
            enable     = tbl[i].en;
            word_valid = tbl[i].val;
            word_in    = tbl[i].word;
            #1;
            chk($sformatf("v%0d_rdy", i), {31'd0, word_ready}, {31'd0, tbl[i].rdy});
            step();
            chk($sformatf("v%0d_ser", i),  {31'd0, ser_out},       {31'd0, tbl[i].ser});
            chk($sformatf("v%0d_txen", i), {31'd0, tx_en},         {31'd0, tbl[i].txen});
            chk($sformatf("v%0d_fs", i),   {31'd0, frame_start},   {31'd0, tbl[i].fs});
            chk($sformatf("v%0d_fid", i),  {31'd0, frame_is_data}, {31'd0, tbl[i].fid});
            chk($sformatf("v%0d_wc", i),   {16'd0, word_cnt},      {16'd0, tbl[i].wc});
        end

        // single word valid from reset, WordIn changes after the accept
        do_reset();
        exp_w      = 32'hA5A5_0001;
        enable     = 1'b1;
        word_valid = 1'b1;
        word_in    = exp_w;
        #1;
        chk("a_rdy", {31'd0, word_ready}, 32'd1);
        step();
        word_valid = 1'b0;
        word_in    = 32'h0;
        chk("a_fs",  {31'd0, frame_start},   32'd1);
        chk("a_fid", {31'd0, frame_is_data}, 32'd1);
        chk("a_wc",  {16'd0, word_cnt},      32'd1);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) begin
                step();
                chk($sformatf("a_fs%0d", i), {31'd0, frame_start}, 32'd0);
            end
            chk($sformatf("a_ser%0d", i), {31'd0, ser_out}, {31'd0, exp_w[31-i]});
        end
        step();
        chk("a_idle_fs",  {31'd0, frame_start},   32'd1);
        chk("a_idle_fid", {31'd0, frame_is_data}, 32'd0);
        chk("a_idle_ser", {31'd0, ser_out},       32'd1);

        // three words with WordValid held high: one accept per 32 cycles
        do_reset();
        words[0]   = 32'h1234_5678;
        words[1]   = 32'hDEAD_BEEF;
        words[2]   = 32'h0F1E_2D3C;
        enable     = 1'b1;
        word_valid = 1'b1;
        word_in    = words[0];
        for (int cyc = 0; cyc < 96; cyc++) begin
            #1;
            chk($sformatf("b_rdy%0d", cyc), {31'd0, word_ready}, {31'd0, (cyc % 32) == 0});
            step();
            if (cyc % 32 == 0) begin
                if (cyc / 32 < 2) begin
                    word_in = words[cyc/32 + 1];
                end else begin
                    word_valid = 1'b0;
                end
            end
            exp_w = words[cyc/32];
            chk($sformatf("b_ser%0d", cyc), {31'd0, ser_out},       {31'd0, exp_w[31 - (cyc % 32)]});
            chk($sformatf("b_fs%0d", cyc),  {31'd0, frame_start},   {31'd0, (cyc % 32) == 0});
            chk($sformatf("b_fid%0d", cyc), {31'd0, frame_is_data}, 32'd1);
        end
        chk("b_wc", {16'd0, word_cnt}, 32'd3);
        #1;
        chk("b_rdy_end", {31'd0, word_ready}, 32'd1);
        step();
        chk("b_end_fid", {31'd0, frame_is_data}, 32'd0);
        chk("b_end_fs",  {31'd0, frame_start},   32'd1);
        chk("b_end_wc",  {16'd0, word_cnt},      32'd3);

        // Enable dropped at bit 10 of a data word, back after a 5-cycle gap
        do_reset();
        enable     = 1'b1;
        word_valid = 1'b1;
        word_in    = 32'hFFFF_FFFF;
        step();
        word_valid = 1'b0;
        for (int i = 1; i <= 10; i++) step();
        chk("c_ser_bit10", {31'd0, ser_out}, 32'd1);
        enable = 1'b0;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk($sformatf("c_rdy%0d", g), {31'd0, word_ready}, 32'd0);
            step();
            chk($sformatf("c_ser%0d", g),  {31'd0, ser_out},       32'd0);
            chk($sformatf("c_txen%0d", g), {31'd0, tx_en},         32'd0);
            chk($sformatf("c_fs%0d", g),   {31'd0, frame_start},   32'd0);
            chk($sformatf("c_fid%0d", g),  {31'd0, frame_is_data}, 32'd0);
        end
        enable = 1'b1;
        #1;
        chk("c_rdy_back", {31'd0, word_ready}, 32'd1);
        step();
        chk("c_ser_back",  {31'd0, ser_out},       32'd1);
        chk("c_fs_back",   {31'd0, frame_start},   32'd1);
        chk("c_fid_back",  {31'd0, frame_is_data}, 32'd0);
        chk("c_txen_back", {31'd0, tx_en},         32'd1);
        chk("c_wc_back",   {16'd0, word_cnt},      32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("c_ser_idle27", {31'd0, ser_out}, 32'd0);

        // WordCnt wrap: counter placed at 16'hFFFF, then one more accept
        force dut.word_cnt = 16'hFFFF;
        #1;
        release dut.word_cnt;
        chk("d_wc_pre", {16'd0, word_cnt}, 32'h0000_FFFF);
        word_valid = 1'b1;
        word_in    = 32'h0000_0001;
        for (int t = 0; t < 40; t++) begin
            if (word_ready) break;
            step();
        end
        chk("d_rdy_timeout", {31'd0, word_ready}, 32'd1);
        step();
        word_valid = 1'b0;
        chk("d_wc_wrap", {16'd0, word_cnt},      32'd0);
        chk("d_fid",     {31'd0, frame_is_data}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
